// File: rtl/piano_pkg.sv
// Shared types for the piano key event path: key vector, encoded index and
// encoder FSM states.
package piano_pkg;

  localparam int NUM_KEYS  = 32;
  localparam int KEY_IDX_W = 5;

  typedef logic [KEY_IDX_W-1:0] key_idx_t;
  typedef logic [NUM_KEYS-1:0]  key_vec_t;

  typedef enum logic {SCAN, SEND} enc_state_e;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus whole-vector debounce: the committed vector only
// follows the synchronised keys once they have held still long enough.
module key_debounce
  import piano_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  key_vec_t keys_raw,
  output key_vec_t keys_stable
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC);

  key_vec_t         sync1, sync2, samp;
  logic [CNT_W-1:0] cnt;

  // Any change in the synchronised vector restarts the hold count, so a bounce
  // on one key also delays commits of keys changing alongside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1       <= '0;
      sync2       <= '0;
      samp        <= '0;
      cnt         <= '0;
      keys_stable <= '0;
    end else begin
      sync1 <= keys_raw;
      sync2 <= sync1;
      if (sync2 != samp) begin
        samp <= sync2;
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      if (cnt == CNT_MAX) keys_stable <= samp;
    end
  end

endmodule

// File: rtl/key_event_encoder32.sv
// Turns debounced key changes into {key_idx, pressed} events, lowest index
// first, delivered one at a time over valid/ready.
module key_event_encoder32
  import piano_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_KEYS-1:0]  keys,
  input  logic                 ready,
  output logic                 valid,
  output logic [KEY_IDX_W-1:0] key_idx,
  output logic                 pressed,
  output logic                 any_down
);

  key_vec_t   committed, reported, reported_n, diff;
  enc_state_e state, state_n;
  key_idx_t   enc_idx, idx_n;
  logic       pressed_n;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
    .clk         (clk),
    .reset       (reset),
    .keys_raw    (keys),
    .keys_stable (committed)
  );

  assign diff  = committed ^ reported;
  assign valid = (state == SEND);

  // Descending scan so the last hit, i.e. the lowest set bit, wins.
  always_comb begin
    enc_idx = '0;
    for (int i = NUM_KEYS-1; i >= 0; i--)
      if (diff[i]) enc_idx = key_idx_t'(i);
  end

  always_comb begin
    state_n    = state;
    idx_n      = key_idx;
    pressed_n  = pressed;
    reported_n = reported;
    case (state)
      SCAN: if (diff != '0) begin
        idx_n     = enc_idx;
        pressed_n = committed[enc_idx];
        state_n   = SEND;
      end
      SEND: if (ready) begin
        // Record what was actually sent; a later change shows up as residual diff.
        reported_n[key_idx] = pressed;
        state_n             = SCAN;
      end
      default: state_n = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= SCAN;
      key_idx  <= '0;
      pressed  <= 1'b0;
      reported <= '0;
      any_down <= 1'b0;
    end else begin
      state    <= state_n;
      key_idx  <= idx_n;
      pressed  <= pressed_n;
      reported <= reported_n;
      any_down <= |reported;
    end
  end

endmodule

// File: tb/tb_key_event_encoder32.sv
// Bench for key_event_encoder32: directed table, multi-cycle corner sequences
// and randomized key batches against an event-list reference model.
module tb_key_event_encoder32;

  typedef struct {logic [4:0] idx; logic pressed;} ev_t;
  typedef struct {logic [31:0] keys; logic [4:0] idx; logic pressed;} vec_t;

  logic        clk = 1'b0;
  logic        reset, ready, valid, pressed, any_down;
  logic [31:0] keys;
  logic [4:0]  key_idx;

  int   errors = 0;
  int   checks = 0;
  ev_t  exp_q[$];
  vec_t tbl[8];

  key_event_encoder32 #(.DEBOUNCE_CYC(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .keys     (keys),
    .ready    (ready),
    .valid    (valid),
    .key_idx  (key_idx),
    .pressed  (pressed),
    .any_down (any_down)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic wait_valid(input int bound, output int k);
    k = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (valid) begin
        k = i;
        break;
      end
    end
  endtask

  // Reference: a settled change old->new yields one event per flipped key,
  // ascending index, carrying the key's new level.
  task automatic expect_changes(input logic [31:0] oldv, input logic [31:0] newv);
    for (int i = 0; i < 32; i++)
      if (oldv[i] != newv[i]) exp_q.push_back('{idx: 5'(i), pressed: newv[i]});
  endtask

  // Consume events until the expected list is empty and the output stays idle.
  task automatic drain(input bit rnd, input int bound);
    int         idle = 0;
    bit         pv = 1'b0, pr = 1'b1;
    logic [4:0] pidx = '0;
    logic       pp = 1'b0;
    ev_t        e;
    for (int c = 0; c < bound; c++) begin
      @(negedge clk);
      if (pv && !pr)
        chk("stall_hold", 32'({valid, pressed, key_idx}), 32'({1'b1, pp, pidx}));
      ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_event: got idx %0d pressed %0d, expected none", key_idx, pressed);
        end else begin
          e = exp_q.pop_front();
          chk("event", 32'({pressed, key_idx}), 32'({e.pressed, e.idx}));
        end
      end
      idle = valid ? 0 : idle + 1;
      pv = valid; pr = ready; pidx = key_idx; pp = pressed;
      if (exp_q.size() == 0 && idle >= 12) return;
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout: %0d events still pending", exp_q.size());
    exp_q.delete();
  endtask

  initial begin
    int          k;
    logic [31:0] cur, nv, gm;
    int          glen;

    tbl[0] = '{keys: 32'h0000_0020, idx: 5'd5,  pressed: 1'b1};
    tbl[1] = '{keys: 32'h0000_0000, idx: 5'd5,  pressed: 1'b0};
    tbl[2] = '{keys: 32'h8000_0000, idx: 5'd31, pressed: 1'b1};
    tbl[3] = '{keys: 32'h0000_0000, idx: 5'd31, pressed: 1'b0};
    tbl[4] = '{keys: 32'h0000_0001, idx: 5'd0,  pressed: 1'b1};
    tbl[5] = '{keys: 32'h0000_0003, idx: 5'd1,  pressed: 1'b1};
    tbl[6] = '{keys: 32'h0000_0001, idx: 5'd1,  pressed: 1'b0};
    tbl[7] = '{keys: 32'h0000_0000, idx: 5'd0,  pressed: 1'b0};

    reset = 1'b1; keys = '0; ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // idle after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle", 32'({valid, any_down, key_idx}), 32'h0);
    end

    // single-key changes: latency, content, single transfer, any_down
    for (int t = 0; t < 8; t++) begin
      keys = tbl[t].keys;
      wait_valid(30, k);
      chk("tbl_latency", 32'(k), 32'd8);
      chk("tbl_idx", 32'(key_idx), 32'(tbl[t].idx));
      chk("tbl_pressed", 32'(pressed), 32'(tbl[t].pressed));
      @(negedge clk);
      chk("tbl_single", 32'(valid), 32'h0);
      @(negedge clk);
      chk("tbl_any_down", 32'(any_down), 32'(|tbl[t].keys));
      repeat (4) begin
        @(negedge clk);
        chk("tbl_no_repeat", 32'(valid), 32'h0);
      end
    end

    // simultaneous presses: 0, 4, 31 on alternate clocks
    keys = 32'h8000_0011;
    wait_valid(30, k);
    chk("multi_latency", 32'(k), 32'd8);
    chk("multi_ev0", 32'({pressed, key_idx}), 32'({1'b1, 5'd0}));
    @(negedge clk); chk("multi_gap0", 32'(valid), 32'h0);
    @(negedge clk); chk("multi_ev1", 32'({valid, pressed, key_idx}), 32'({2'b11, 5'd4}));
    @(negedge clk); chk("multi_gap1", 32'(valid), 32'h0);
    @(negedge clk); chk("multi_ev2", 32'({valid, pressed, key_idx}), 32'({2'b11, 5'd31}));
    @(negedge clk); chk("multi_gap2", 32'(valid), 32'h0);
    @(negedge clk); chk("multi_any_down", 32'(any_down), 32'h1);
    keys = '0;
    expect_changes(32'h8000_0011, 32'h0);
    drain(1'b0, 200);
    chk("multi_release_any_down", 32'(any_down), 32'h0);

    // back-pressure: event held stable, one transfer only
    ready = 1'b0;
    keys = 32'h0000_1000;
    wait_valid(30, k);
    chk("stall_latency", 32'(k), 32'd8);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall", 32'({valid, pressed, key_idx}), 32'({2'b11, 5'd12}));
    end
    ready = 1'b1;
    @(negedge clk); chk("stall_release", 32'(valid), 32'h0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall_no_repeat", 32'(valid), 32'h0);
    end
    chk("stall_any_down", 32'(any_down), 32'h1);

    // key 7 released while its press is still pending: press, then follow-up release
    ready = 1'b0;
    keys = 32'h0000_1080;
    wait_valid(30, k);
    chk("pend_ev", 32'({pressed, key_idx}), 32'({1'b1, 5'd7}));
    keys = 32'h0000_1000;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("pend_hold", 32'({valid, pressed, key_idx}), 32'({2'b11, 5'd7}));
    end
    exp_q.push_back('{idx: 5'd7, pressed: 1'b1});
    exp_q.push_back('{idx: 5'd7, pressed: 1'b0});
    drain(1'b0, 100);
    chk("pend_any_down", 32'(any_down), 32'h1);
    keys = '0;
    expect_changes(32'h0000_1000, 32'h0);
    drain(1'b0, 100);

    // short glitch is discarded
    keys = 32'h0000_0400;
    repeat (2) @(negedge clk);
    keys = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("glitch", 32'(valid), 32'h0);
    end

    // reset while an event is stalled, key held through reset
    ready = 1'b0;
    keys = 32'h0000_0008;
    wait_valid(30, k);
    chk("rst_pre_ev", 32'({pressed, key_idx}), 32'({1'b1, 5'd3}));
    reset = 1'b1;
    @(negedge clk);
    chk("rst_drop", 32'({valid, any_down}), 32'h0);
    reset = 1'b0;
    wait_valid(30, k);
    chk("rst_relatency", 32'(k), 32'd8);
    chk("rst_reev", 32'({pressed, key_idx}), 32'({1'b1, 5'd3}));
    exp_q.push_back('{idx: 5'd3, pressed: 1'b1});
    drain(1'b0, 100);
    keys = '0;
    expect_changes(32'h0000_0008, 32'h0);
    drain(1'b0, 100);

    // randomized batches with glitches and random ready
    cur = '0;
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 1) == 1) begin
        gm   = $urandom;
        glen = $urandom_range(1, 3);
        keys = cur ^ gm;
        repeat (glen) @(negedge clk);
      end
      nv = cur ^ (($urandom_range(0, 3) == 0) ? $urandom : ($urandom & $urandom & $urandom));
      keys = nv;
      expect_changes(cur, nv);
      drain(1'b1, 2000);
      ready = 1'b1;
      chk("rand_any_down", 32'(any_down), 32'(|nv));
      cur = nv;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
